// File: rtl/aes_round_ctrl.sv
// AES round sequencer: initial AddRoundKey on acceptance, then NR iterations through an
// external combinational round datapath, holding the ciphertext until the consumer takes it.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] round_key,
  output logic [127:0] rd_in,
  output logic         rd_final,
  input  logic [127:0] rd_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} fsm_e;

  localparam logic [3:0] LastRnd = 4'(NR);

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic [3:0]   rnd_q;
  logic         last_rnd;

  assign last_rnd = (rnd_q == LastRnd);

  // Sequencer: control state, cipher state and round counter advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= StIdle;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      case (fsm_q)
        StIdle: begin
          if (in_valid) begin
            // rk_idx is 0 here, so round_key is the whitening key.
            state_q <= data_in ^ round_key;
            rnd_q   <= 4'd1;
            fsm_q   <= StRound;
          end
        end
        StRound: begin
          state_q <= rd_out ^ round_key;
          if (last_rnd) begin
            fsm_q <= StDone;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        StDone: begin
          // State is left untouched so data_out stays valid through the handshake.
          if (out_ready) begin
            fsm_q <= StIdle;
          end
        end
        default: begin
          fsm_q <= StIdle;
        end
      endcase
    end
  end

  // Output decode: every output is a function of registered state only.
  always_comb begin
    in_ready  = (fsm_q == StIdle);
    busy      = (fsm_q != StIdle);
    out_valid = (fsm_q == StDone);
    rd_final  = (fsm_q == StRound) && last_rnd;
    rk_idx    = (fsm_q == StRound) ? rnd_q : 4'd0;
    rd_in     = state_q;
    data_out  = state_q;
  end

endmodule
